itch_msg_tx: RTL and testbench

ITCH_MSG_TX -- requirements
Module: itch_msg_tx

---
 rtl/itch_msg_tx.sv | 131 +++++++++++++
 tb/tb_itch_msg_tx.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/itch_msg_tx.sv
// rtl/itch_msg_tx.sv - ITCH message serializer: 3-byte header plus payload onto a byte stream
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   hdr_valid/hdr_ready           header handshake carrying msg_type[7:0], msg_len[15:0]
//   pl_data/pl_valid/pl_ready     payload byte input stream
//   tx_data/tx_valid/tx_ready     serialized output byte stream (registered)
//   tx_last                       marks the final byte of a message
//   done                          one-cycle pulse after the final byte transfers
module itch_msg_tx (
    input  logic        clk,
    input  logic        rst,
    input  logic        hdr_valid,
    output logic        hdr_ready,
    input  logic [7:0]  msg_type,
    input  logic [15:0] msg_len,
    input  logic [7:0]  pl_data,
    input  logic        pl_valid,
    output logic        pl_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_last,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_PAYLOAD,
        S_DRAIN
    } state_t;

    state_t      r_state;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;
    logic        r_tx_last;
    logic        r_done;
    logic [15:0] r_len;
    logic [15:0] r_remaining;

    logic        w_load_ok;

    // The output register may take a new byte when it is empty or being drained this cycle.
    assign w_load_ok = !r_tx_valid || tx_ready;

    assign hdr_ready = (r_state == S_IDLE);
    assign pl_ready  = (r_state == S_PAYLOAD) && w_load_ok;

    assign tx_data   = r_tx_data;
    assign tx_valid  = r_tx_valid;
    assign tx_last   = r_tx_last;
    assign done      = r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_tx_data   <= 8'h00;
            r_tx_valid  <= 1'b0;
            r_tx_last   <= 1'b0;
            r_done      <= 1'b0;
            r_len       <= 16'h0000;
            r_remaining <= 16'h0000;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // The type byte goes straight into the output register, so only the
                    // length needs a separate latch for the following two cycles.
                    if (hdr_valid) begin
                        r_len      <= msg_len;
                        r_tx_data  <= msg_type;
                        r_tx_valid <= 1'b1;
                        r_tx_last  <= 1'b0;
                        r_state    <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (w_load_ok) begin
                        r_tx_data  <= r_len[15:8];
                        r_tx_valid <= 1'b1;
                        r_state    <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (w_load_ok) begin
                        r_tx_data   <= r_len[7:0];
                        r_tx_valid  <= 1'b1;
                        r_remaining <= r_len;
                        if (r_len == 16'h0000) begin
                            r_tx_last <= 1'b1;
                            r_state   <= S_DRAIN;
                        end else begin
                            r_state   <= S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (w_load_ok) begin
                        if (pl_valid) begin
                            r_tx_data   <= pl_data;
                            r_tx_valid  <= 1'b1;
                            r_remaining <= r_remaining - 16'd1;
                            if (r_remaining == 16'd1) begin
                                r_tx_last <= 1'b1;
                                r_state   <= S_DRAIN;
                            end
                        end else begin
                            // No payload available: emit a bubble rather than stall the pipe.
                            r_tx_valid <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    // The final byte sits in the output register until it transfers.
                    if (tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_tx_last  <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_itch_msg_tx.sv
// tb/tb_itch_msg_tx.sv - randomized self-checking bench for itch_msg_tx against a byte-queue model
module tb_itch_msg_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hdr_valid = 1'b0;
    logic        hdr_ready;
    logic [7:0]  msg_type = 8'h00;
    logic [15:0] msg_len = 16'h0000;
    logic [7:0]  pl_data = 8'h00;
    logic        pl_valid = 1'b0;
    logic        pl_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        tx_last;
    logic        done;

    itch_msg_tx dut (
        .clk       (clk),
        .rst       (rst),
        .hdr_valid (hdr_valid),
        .hdr_ready (hdr_ready),
        .msg_type  (msg_type),
        .msg_len   (msg_len),
        .pl_data   (pl_data),
        .pl_valid  (pl_valid),
        .pl_ready  (pl_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_last   (tx_last),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  t;
        logic [15:0] l;
    } hdr_t;

    typedef struct {
        logic [7:0] d;
        logic       last;
        int         pos;
    } item_t;

    hdr_t       hq[$];
    logic [7:0] pend[$];
    logic [7:0] src[$];
    item_t      exp_q[$];
    logic       pat_q[$];
    int         hs_q[$];
    int         end_q[$];

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   rdy_pct = 100;
    int   pl_pct = 100;
    int   stall_left = 0;
    int   pl_taken = 0;
    bit   hold_hdr = 1'b1;
    bit   active = 1'b0;
    bit   exp_done = 1'b0;
    bit   prev_stall = 1'b0;
    bit   prev_bubble = 1'b0;
    logic [7:0] p_data;
    logic       p_last;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic add_msg(input logic [7:0] t, input logic [15:0] l);
        hdr_t h;
        h.t = t;
        h.l = l;
        hq.push_back(h);
        for (int i = 0; i < int'(l); i++) pend.push_back(8'($urandom));
    endtask

    // One clock cycle: check visible outputs, drive inputs, then predict the handshakes
    // that will occur on the coming rising edge.
    task automatic step();
        item_t it;
        hdr_t  h;
        logic [7:0] b;
        @(negedge clk);
        if (prev_stall) chk("hold", {23'd0, tx_valid, tx_last, tx_data}, {23'd0, 1'b1, p_last, p_data});
        if (prev_bubble) chk("bubble", {31'd0, tx_valid}, 32'd0);
        chk("done", {31'd0, done}, {31'd0, exp_done});
        chk("hdr_ready", {31'd0, hdr_ready}, {31'd0, !active});

        tx_ready = ($urandom_range(99) < rdy_pct);
        if (stall_left > 0 && tx_valid && exp_q.size() > 0 && exp_q[0].pos == 1) begin
            tx_ready = 1'b0;
            stall_left--;
        end
        if (hq.size() > 0) begin
            hdr_valid = hold_hdr ? 1'b1 : 1'($urandom_range(1));
            msg_type  = hq[0].t;
            msg_len   = hq[0].l;
        end else begin
            hdr_valid = 1'b0;
            msg_type  = 8'($urandom);
            msg_len   = 16'($urandom);
        end
        pl_valid = 1'b0;
        pl_data  = 8'($urandom);
        #1;
        if (src.size() > 0) begin
            if (pat_q.size() > 0 && pl_ready) pl_valid = pat_q.pop_front();
            else if (pat_q.size() == 0) pl_valid = ($urandom_range(99) < pl_pct);
            if (pl_valid) pl_data = src[0];
        end else begin
            chk("pl_ready_idle", {31'd0, pl_ready}, 32'd0);
        end
        #1;

        exp_done = 1'b0;
        if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
            end else begin
                it = exp_q.pop_front();
                chk("tx_byte", {23'd0, tx_last, tx_data}, {23'd0, it.last, it.d});
                if (it.last) begin
                    exp_done = 1'b1;
                    active   = 1'b0;
                    end_q.push_back(cyc);
                end
            end
        end
        if (hdr_valid && hdr_ready) begin
            h = hq.pop_front();
            active = 1'b1;
            hs_q.push_back(cyc);
            it.d = h.t;        it.last = 1'b0;          it.pos = 0; exp_q.push_back(it);
            it.d = h.l[15:8];  it.last = 1'b0;          it.pos = 1; exp_q.push_back(it);
            it.d = h.l[7:0];   it.last = (h.l == 16'd0); it.pos = 2; exp_q.push_back(it);
            for (int i = 0; i < int'(h.l); i++) begin
                b = pend.pop_front();
                src.push_back(b);
                it.d = b; it.last = (i == int'(h.l) - 1); it.pos = 3 + i;
                exp_q.push_back(it);
            end
        end
        if (pl_valid && pl_ready) begin
            void'(src.pop_front());
            pl_taken++;
        end
        prev_stall  = tx_valid && !tx_ready;
        prev_bubble = pl_ready && !pl_valid;
        p_data = tx_data;
        p_last = tx_last;
        cyc++;
    endtask

    task automatic run_idle(input int cap);
        int n = 0;
        while ((hq.size() > 0 || active) && n < cap) begin
            step();
            n++;
        end
        chk("timeout", {31'd0, (n < cap)}, 32'd1);
        step();
        step();
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_tx_last", {31'd0, tx_last}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_pl_ready", {31'd0, pl_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic 3-byte message at full rate, N+3 consecutive cycles
        rdy_pct = 100; pl_pct = 100; hold_hdr = 1'b1;
        hq.delete(); pend.delete();
        begin
            hdr_t h; h.t = 8'h41; h.l = 16'd3; hq.push_back(h);
            pend.push_back(8'h11); pend.push_back(8'h22); pend.push_back(8'h33);
        end
        run_idle(50);
        chk("full_rate_3", end_q[$] - hs_q[$], 6);

        // Zero-length message
        add_msg(8'h53, 16'd0);
        run_idle(50);
        chk("full_rate_0", end_q[$] - hs_q[$], 3);

        // Length-high byte stalled for three cycles
        stall_left = 3;
        add_msg(8'h60, 16'd2);
        run_idle(50);
        chk("stall_used", stall_left, 0);

        // Gapped payload
        pat_q = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        add_msg(8'h61, 16'd4);
        run_idle(50);
        chk("pattern_used", pat_q.size(), 0);

        // Back-to-back headers with hdr_valid held high
        add_msg(8'h70, 16'd5);
        add_msg(8'h71, 16'd1);
        run_idle(100);
        chk("b2b_gap", hs_q[$] - end_q[end_q.size() - 2], 1);
        chk("full_rate_1", end_q[$] - hs_q[$], 4);

        // Randomized traffic
        for (int m = 0; m < 25; m++) begin
            rdy_pct  = $urandom_range(40, 100);
            pl_pct   = $urandom_range(40, 100);
            hold_hdr = 1'($urandom_range(1));
            add_msg(8'($urandom), 16'($urandom_range(0, 24)));
            if ($urandom_range(1) == 1) add_msg(8'($urandom), 16'($urandom_range(0, 6)));
            run_idle(2000);
        end

        // Reset mid-message after two payload bytes
        rdy_pct = 100; pl_pct = 100; hold_hdr = 1'b1;
        pl_taken = 0;
        add_msg(8'h44, 16'd10);
        begin
            int n = 0;
            while (pl_taken < 2 && n < 100) begin
                step();
                n++;
            end
            chk("reset_setup", {31'd0, (n < 100)}, 32'd1);
        end
        #1 rst = 1'b1;
        #1;
        chk("arst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("arst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("arst_tx_last", {31'd0, tx_last}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_pl_ready", {31'd0, pl_ready}, 32'd0);
        hq.delete(); pend.delete(); src.delete(); exp_q.delete(); pat_q.delete();
        active = 1'b0; exp_done = 1'b0; prev_stall = 1'b0; prev_bubble = 1'b0;
        hdr_valid = 1'b0; pl_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) step();

        // A message after the aborted one is intact
        add_msg(8'h45, 16'd2);
        run_idle(50);

        // Maximum length without counter wrap
        rdy_pct = 100; pl_pct = 100;
        add_msg(8'h5A, 16'hFFFF);
        run_idle(70000);
        chk("full_rate_max", end_q[$] - hs_q[$], 65538);
        chk("exp_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
